// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
//
// Fetch stage that sits in front of the main Control decoder. It owns the
// program counter, issues one instruction-memory read at a time, holds the
// returned word for decode and, once decode lets go (Stall low), steps the PC
// to the sequential, branch or jump target resolved for the held instruction.
//
// Every instruction takes at least two cycles: one REQ cycle, in which memory
// may answer immediately, and one HOLD cycle, in which the word is presented to
// decode.
//
// Parameters
//   RESET_PC      PC loaded on reset. Must be word aligned.
//
// Ports
//   clk           single clock, rising edge
//   reset         asynchronous, active-high reset
//   Stall         downstream hold; freezes the held instruction and PC
//   Jump          Control's jump decision for the held instruction
//   Branch        Control's branch decision for the held instruction
//   Zero          ALU zero flag for the held instruction
//   BranchOffset  sign-extended word offset for a taken branch
//   JumpIndex     Instr[25:0] of the held jump
//   MemReq        instruction-memory read request (high in REQ)
//   MemAddr       byte address of the request (always equal to PC)
//   MemRdata      instruction word returned by memory
//   MemValid      MemRdata is valid; only looked at in REQ
//   Instr         held instruction word
//   OpCode        Instr[31:26], drives Control
//   InstrValid    Instr/OpCode/PC are valid for decode this cycle (HOLD)
//   PC            address of the held instruction
//   PCPlus4       PC + 4, modulo 2^32
//
// Optional build (macro FETCH_PERF_EN)
//   FetchCount    number of HOLD->REQ transitions since reset, wraps at 2^32
//   StallCount    HOLD cycles with Stall high plus REQ cycles without
//                 MemValid, since reset, wraps at 2^32
//   With the macro undefined these ports and counters do not exist and the
//   fetch behaviour is unchanged.
// -----------------------------------------------------------------------------
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00400000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        Zero,
    input  logic [31:0] BranchOffset,
    input  logic [25:0] JumpIndex,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic [31:0] MemRdata,
    input  logic        MemValid,
    output logic [31:0] Instr,
    output logic [5:0]  OpCode,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount
`endif
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetchState_t;

    fetchState_t stateReg;
    fetchState_t stateNext;

    logic [31:0] pcReg;
    logic [31:0] pcNext;
    logic [31:0] instrReg;
    logic [31:0] instrNext;

    logic        memReqComb;
    logic        instrValidComb;

    // -------------------------------------------------------------------------
    // Next-PC datapath
    //
    // All three candidate targets are built from PC + 4. The branch offset is
    // a word offset, so it is shifted left by two; the two bits shifted out of
    // the top are discarded along with any carry, which gives plain modulo-2^32
    // arithmetic. A jump keeps the upper nibble of PC + 4 (the region of the
    // delay-slot address) and replaces the rest with the word index.
    // -------------------------------------------------------------------------
    logic [31:0] pcPlus4Comb;
    logic [31:0] branchTarget;
    logic [31:0] jumpTarget;
    logic [31:0] redirectPc;
    logic        branchTaken;

    assign pcPlus4Comb  = pcReg + 32'd4;
    assign branchTarget = pcPlus4Comb + {BranchOffset[29:0], 2'b00};
    assign jumpTarget   = {pcPlus4Comb[31:28], JumpIndex, 2'b00};
    assign branchTaken  = Branch & Zero;

    // Jump outranks a taken branch when Control raises both.
    always_comb begin
        redirectPc = pcPlus4Comb;
        if (Jump) begin
            redirectPc = jumpTarget;
        end else if (branchTaken) begin
            redirectPc = branchTarget;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    //
    // The asynchronous reset clears the state immediately, so MemReq (decoded
    // from the state below) drops at once and any request in flight is simply
    // forgotten; memory is reset alongside us.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
            pcReg    <= RESET_PC;
            instrReg <= 32'd0;
        end else begin
            stateReg <= stateNext;
            pcReg    <= pcNext;
            instrReg <= instrNext;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    //
    // REQ  : request is held with a stable address until memory answers; a
    //        same-cycle answer is allowed. Stall has no effect here because
    //        nothing is being presented to decode yet.
    // HOLD : the captured word is presented. Control inputs are only trusted
    //        here, and only on the cycle decode releases the stage.
    // MemValid outside REQ is a stray strobe and is never looked at.
    // -------------------------------------------------------------------------
    always_comb begin
        stateNext      = stateReg;
        pcNext         = pcReg;
        instrNext      = instrReg;
        memReqComb     = 1'b0;
        instrValidComb = 1'b0;

        case (stateReg)
            IDLE: begin
                stateNext = REQ;
            end

            REQ: begin
                memReqComb = 1'b1;
                if (MemValid) begin
                    instrNext = MemRdata;
                    stateNext = HOLD;
                end
            end

            HOLD: begin
                instrValidComb = 1'b1;
                if (!Stall) begin
                    pcNext    = redirectPc;
                    stateNext = REQ;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign MemReq     = memReqComb;
    assign MemAddr    = pcReg;
    assign Instr      = instrReg;
    assign OpCode     = instrReg[31:26];
    assign InstrValid = instrValidComb;
    assign PC         = pcReg;
    assign PCPlus4    = pcPlus4Comb;

`ifdef FETCH_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters
    //
    // A fetch is counted when a held instruction is released to the next
    // request. A stall cycle is either decode holding us in HOLD or memory
    // keeping us waiting in REQ; the two can never coincide since they belong
    // to different states.
    // -------------------------------------------------------------------------
    logic [31:0] fetchCountReg;
    logic [31:0] stallCountReg;
    logic        fetchEvent;
    logic        stallEvent;

    assign fetchEvent = (stateReg == HOLD) && !Stall;
    assign stallEvent = ((stateReg == HOLD) && Stall) ||
                        ((stateReg == REQ) && !MemValid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchCountReg <= 32'd0;
            stallCountReg <= 32'd0;
        end else begin
            if (fetchEvent) begin
                fetchCountReg <= fetchCountReg + 32'd1;
            end
            if (stallEvent) begin
                stallCountReg <= stallCountReg + 32'd1;
            end
        end
    end

    assign FetchCount = fetchCountReg;
    assign StallCount = stallCountReg;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_stage
//
// Directed bench for instr_fetch_stage. Every request address the stage is
// expected to issue is pushed to addrQ when the redirect is driven, and every
// word handed to the stage is pushed to instrQ together with its address; both
// are popped when the stage shows the request or presents the instruction.
// Build with +define+FETCH_PERF_EN to also check the counters.
// -----------------------------------------------------------------------------
module tb_instr_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h00400000;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        Jump;
    logic        Branch;
    logic        Zero;
    logic [31:0] BranchOffset;
    logic [25:0] JumpIndex;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic [31:0] MemRdata;
    logic        MemValid;
    logic [31:0] Instr;
    logic [5:0]  OpCode;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
`ifdef FETCH_PERF_EN
    logic [31:0] FetchCount;
    logic [31:0] StallCount;
`endif

    instr_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .Stall        (Stall),
        .Jump         (Jump),
        .Branch       (Branch),
        .Zero         (Zero),
        .BranchOffset (BranchOffset),
        .JumpIndex    (JumpIndex),
        .MemReq       (MemReq),
        .MemAddr      (MemAddr),
        .MemRdata     (MemRdata),
        .MemValid     (MemValid),
        .Instr        (Instr),
        .OpCode       (OpCode),
        .InstrValid   (InstrValid),
        .PC           (PC),
        .PCPlus4      (PCPlus4)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount   (FetchCount),
        .StallCount   (StallCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nAsserts = 0;
    int nFail    = 0;

    logic [31:0] addrQ[$];
    logic [63:0] instrQ[$];   // {address, word}

    logic [31:0] modelPc;
    logic [31:0] modelInstr;
    int          fetchM;
    int          stallM;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs driven
    // there are taken by the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] nextPc(input logic [31:0] pc, input logic j,
                                           input logic b, input logic z,
                                           input logic [31:0] off, input logic [25:0] idx);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        if (j)
            return {p4[31:28], idx, 2'b00};
        else if (b && z)
            return p4 + (off << 2);
        else
            return p4;
    endfunction

    // Called with the stage in REQ. Memory answers after 'latency' empty
    // cycles; Stall is held high meanwhile since REQ must ignore it.
    task automatic doFetch(input logic [31:0] data, input int latency);
        logic [31:0] a;
        logic [63:0] e;
        if (addrQ.size() == 0) begin
            check("addrq_empty", 32'd0, 32'd1);
            a = 32'hxxxxxxxx;
        end else begin
            a = addrQ.pop_front();
        end
        check("req_memreq", 32'(MemReq), 32'd1);
        check("req_addr", MemAddr, a);
        check("req_ivalid", 32'(InstrValid), 32'd0);
        for (int i = 0; i < latency; i++) begin
            Stall    = 1'b1;
            MemValid = 1'b0;
            stallM++;
            tick();
            check("wait_memreq", 32'(MemReq), 32'd1);
            check("wait_addr", MemAddr, a);
        end
        MemValid = 1'b1;
        MemRdata = data;
        instrQ.push_back({a, data});
        tick();
        MemValid = 1'b0;
        MemRdata = $urandom;
        Stall    = 1'b0;
        e = instrQ.pop_front();
        check("hold_ivalid", 32'(InstrValid), 32'd1);
        check("hold_memreq", 32'(MemReq), 32'd0);
        check("hold_instr", Instr, e[31:0]);
        check("hold_opcode", 32'(OpCode), 32'(e[31:26]));
        check("hold_pc", PC, e[63:32]);
        check("hold_pcplus4", PCPlus4, e[63:32] + 32'd4);
        modelPc    = e[63:32];
        modelInstr = e[31:0];
    endtask

    // Called with the stage in HOLD. Holds it for 'stalls' cycles with junk on
    // the control inputs, optionally with a stray MemValid, then releases it
    // with the given control decisions.
    task automatic doRelease(input logic j, input logic b, input logic z,
                             input logic [31:0] off, input logic [25:0] idx,
                             input int stalls, input logic stray);
        logic [31:0] nxt;
        for (int i = 0; i < stalls; i++) begin
            Stall        = 1'b1;
            Jump         = 1'($urandom);
            Branch       = 1'b1;
            Zero         = 1'b1;
            BranchOffset = $urandom;
            JumpIndex    = 26'($urandom);
            if (stray && i == 0) begin
                MemValid = 1'b1;
                MemRdata = ~modelInstr;
            end
            stallM++;
            tick();
            MemValid = 1'b0;
            check("stall_ivalid", 32'(InstrValid), 32'd1);
            check("stall_memreq", 32'(MemReq), 32'd0);
            check("stall_instr", Instr, modelInstr);
            check("stall_pc", PC, modelPc);
        end
        Stall        = 1'b0;
        Jump         = j;
        Branch       = b;
        Zero         = z;
        BranchOffset = off;
        JumpIndex    = idx;
        nxt = nextPc(modelPc, j, b, z, off, idx);
        addrQ.push_back(nxt);
        fetchM++;
        tick();
        Jump   = 1'b0;
        Branch = 1'b0;
        Zero   = 1'b0;
        check("rel_ivalid", 32'(InstrValid), 32'd0);
        check("rel_pc", PC, nxt);
    endtask

    task automatic checkCounters(input string tag);
`ifdef FETCH_PERF_EN
        check({tag, "_fetchcnt"}, FetchCount, 32'(fetchM));
        check({tag, "_stallcnt"}, StallCount, 32'(stallM));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        Stall        = 1'b0;
        Jump         = 1'b0;
        Branch       = 1'b0;
        Zero         = 1'b0;
        BranchOffset = 32'd0;
        JumpIndex    = 26'd0;
        MemRdata     = 32'd0;
        MemValid     = 1'b0;
        fetchM       = 0;
        stallM       = 0;
        modelPc      = RESET_PC;
        modelInstr   = 32'd0;

        // Reset state
        tick();
        tick();
        check("rst_memreq", 32'(MemReq), 32'd0);
        check("rst_ivalid", 32'(InstrValid), 32'd0);
        check("rst_instr", Instr, 32'd0);
        check("rst_opcode", 32'(OpCode), 32'd0);
        check("rst_pc", PC, RESET_PC);
        check("rst_pcplus4", PCPlus4, 32'h00400004);
        checkCounters("rst");

        // Release: IDLE for one cycle, then REQ; memory answers at once
        reset = 1'b0;
        addrQ.push_back(RESET_PC);
        check("idle_memreq", 32'(MemReq), 32'd0);
        tick();
        check("first_addr", MemAddr, 32'h00400000);
        doFetch(32'h20080005, 0);
        check("first_opcode", 32'(OpCode), 32'h08);

        // Sequential fetches
        doRelease(1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 0, 1'b0);
        check("seq_addr2", MemAddr, 32'h00400004);
        doFetch(32'h8D090004, 0);
        doRelease(1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 0, 1'b0);
        check("seq_addr3", MemAddr, 32'h00400008);
        doFetch(32'h1109FFFE, 0);

        // Taken branch backwards, then the same branch not taken
        doRelease(1'b0, 1'b1, 1'b1, 32'hFFFFFFFE, 26'd0, 0, 1'b0);
        check("br_taken_addr", MemAddr, 32'h00400004);
        doFetch(32'h8D090004, 0);
        doRelease(1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 0, 1'b0);
        doFetch(32'h1109FFFE, 0);
        doRelease(1'b0, 1'b1, 1'b0, 32'hFFFFFFFE, 26'd0, 0, 1'b0);
        check("br_nottaken_addr", MemAddr, 32'h0040000C);
        doFetch(32'h01095020, 0);
        doRelease(1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 0, 1'b0);
        doFetch(32'h08100003, 0);

        // Jump with a taken branch alongside: jump wins
        doRelease(1'b1, 1'b1, 1'b1, 32'h00000010, 26'h0100003, 0, 1'b0);
        check("jump_addr", MemAddr, 32'h0040000C);
        checkCounters("pre_lat");

        // Four-cycle memory latency, then three stall cycles with a stray
        // MemValid in the first of them
        doFetch(32'hAD0A0008, 4);
        doRelease(1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 3, 1'b1);
        checkCounters("post_stall");

        // Reset in the middle of a request
        check("midreq_addr", MemAddr, 32'h00400010);
        void'(addrQ.pop_front());
        MemValid = 1'b0;
        stallM += 2;
        tick();
        tick();
        check("midreq_memreq", 32'(MemReq), 32'd1);
        reset = 1'b1;
        #1;
        check("async_memreq", 32'(MemReq), 32'd0);
        check("async_pc", PC, RESET_PC);
        check("async_ivalid", 32'(InstrValid), 32'd0);
        check("async_instr", Instr, 32'd0);
        addrQ.delete();
        instrQ.delete();
        fetchM = 0;
        stallM = 0;
        checkCounters("async");
        tick();
        reset = 1'b0;
        addrQ.push_back(RESET_PC);
        tick();
        check("restart_addr", MemAddr, RESET_PC);

        // Two fetches and three stall cycles from reset; second release
        // branches to the last word of the address space
        doFetch(32'h20080005, 0);
        doRelease(1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 0, 1'b0);
        doFetch(32'h1000FFFF, 0);
        doRelease(1'b0, 1'b1, 1'b1, 32'hFFEFFFFD, 26'd0, 3, 1'b0);
        check("top_addr", MemAddr, 32'hFFFFFFFC);
`ifdef FETCH_PERF_EN
        check("perf_fetch2", FetchCount, 32'd2);
        check("perf_stall3", StallCount, 32'd3);
`endif

        // Sequential step across the top of the address space
        doFetch(32'h00000000, 1);
        check("wrap_pcplus4", PCPlus4, 32'h00000000);
        doRelease(1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 0, 1'b0);
        check("wrap_addr", MemAddr, 32'h00000000);
        doFetch(32'h3C011001, 0);
        checkCounters("final");

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
